// File: rtl/geiger_packetizer_multi.sv
// rtl/geiger_packetizer_multi.sv - multi-channel Geiger pulse counter with framed, checksummed byte packetizer
// Gate-window counting with per-channel dead time; snapshot streamed as SYNC/TS/CNT/CHK bytes.
module geiger_packetizer_multi #(
    parameter int          NUM_CH       = 2,
    parameter int          CNT_W        = 16,
    parameter int          TS_W         = 48,
    parameter int          WINDOW_CYC   = 1000000,
    parameter int          DEADTIME_CYC = 100,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic              CLK_1MHZ,
    input  logic              NSYSRESET,
    input  logic              EN,
    input  logic [NUM_CH-1:0] GEIG_IN,
    input  logic [TS_W-1:0]   TIMESTAMP,
    output logic [7:0]        DATA_OUT,
    output logic              DATA_VALID,
    input  logic              DATA_READY,
    output logic              FRAME_START,
    output logic              OVERRUN
);

    localparam int TS_B  = TS_W / 8;
    localparam int CNT_B = CNT_W / 8;
    localparam int PAY_B = TS_B + NUM_CH * CNT_B;
    localparam int PAY_W = 8 * PAY_B;
    localparam int WIN_W = $clog2(WINDOW_CYC + 1);
    localparam int DT_W  = $clog2(DEADTIME_CYC + 1);
    localparam int IDX_W = $clog2(PAY_B + 1);

    typedef enum logic [2:0] {IDLE, SYNC, TS, CNT, CHK} state_t;

    state_t            state;
    logic [NUM_CH-1:0] sync1, sync2, sync3, pulse;
    logic [NUM_CH-1:0] accept;
    logic [DT_W-1:0]   dt_cnt     [NUM_CH];
    logic [CNT_W-1:0]  live_cnt   [NUM_CH];
    logic [CNT_W-1:0]  close_cnt  [NUM_CH];
    logic [CNT_W-1:0]  shadow_cnt [NUM_CH];
    logic [TS_W-1:0]   shadow_ts;
    logic [WIN_W-1:0]  win_cnt;
    logic [PAY_W-1:0]  payload;
    logic [IDX_W-1:0]  idx;
    logic [7:0]        chk;
    logic [7:0]        next_byte;
    logic              term;
    logic              xfer;

    assign term = EN && (win_cnt == WIN_W'(WINDOW_CYC - 1));
    assign xfer = DATA_VALID && DATA_READY;

    // close_cnt is the live count including an edge accepted this cycle, so a
    // terminal-cycle edge lands in the closing snapshot.
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            accept[ch]    = EN && pulse[ch] && (dt_cnt[ch] == '0);
            close_cnt[ch] = (accept[ch] && (live_cnt[ch] != '1)) ? live_cnt[ch] + 1'b1 : live_cnt[ch];
        end
    end

    // Channel 0 sits immediately after the timestamp, so it is sent first.
    always_comb begin
        payload = '0;
        payload[PAY_W-1 -: TS_W] = shadow_ts;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            payload[CNT_W*(NUM_CH-1-ch) +: CNT_W] = shadow_cnt[ch];
        end
    end

    assign next_byte = 8'(payload >> (8 * (PAY_B - 1 - int'(idx))));

    always_ff @(posedge CLK_1MHZ or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
            pulse <= '0;
        end else begin
            sync1 <= GEIG_IN;
            sync2 <= sync1;
            sync3 <= sync2;
            pulse <= sync2 & ~sync3;
        end
    end

    always_ff @(posedge CLK_1MHZ or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            win_cnt <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                dt_cnt[ch]   <= '0;
                live_cnt[ch] <= '0;
            end
        end else begin
            win_cnt <= (!EN || term) ? '0 : win_cnt + 1'b1;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (accept[ch])
                    dt_cnt[ch] <= DT_W'(DEADTIME_CYC - 1);
                else if (dt_cnt[ch] != '0)
                    dt_cnt[ch] <= dt_cnt[ch] - 1'b1;
                live_cnt[ch] <= (!EN || term) ? '0 : close_cnt[ch];
            end
        end
    end

    always_ff @(posedge CLK_1MHZ or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            state       <= IDLE;
            DATA_OUT    <= '0;
            DATA_VALID  <= 1'b0;
            FRAME_START <= 1'b0;
            OVERRUN     <= 1'b0;
            idx         <= '0;
            chk         <= '0;
            shadow_ts   <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) shadow_cnt[ch] <= '0;
        end else begin
            OVERRUN <= 1'b0;
            if (term) begin
                if (state == IDLE) begin
                    shadow_cnt <= close_cnt;
                    shadow_ts  <= TIMESTAMP;
                end else begin
                    OVERRUN <= 1'b1;
                end
            end
            case (state)
                IDLE: if (term) begin
                    state       <= SYNC;
                    DATA_OUT    <= SYNC_BYTE;
                    DATA_VALID  <= 1'b1;
                    FRAME_START <= 1'b1;
                    idx         <= '0;
                    chk         <= '0;
                end
                SYNC: if (xfer) begin
                    FRAME_START <= 1'b0;
                    DATA_OUT    <= next_byte;
                    idx         <= idx + 1'b1;
                    state       <= TS;
                end
                TS: if (xfer) begin
                    chk      <= chk ^ DATA_OUT;
                    DATA_OUT <= next_byte;
                    idx      <= idx + 1'b1;
                    if (idx == IDX_W'(TS_B)) state <= CNT;
                end
                CNT: if (xfer) begin
                    chk <= chk ^ DATA_OUT;
                    if (idx == IDX_W'(PAY_B)) begin
                        DATA_OUT <= chk ^ DATA_OUT;
                        state    <= CHK;
                    end else begin
                        DATA_OUT <= next_byte;
                        idx      <= idx + 1'b1;
                    end
                end
                CHK: if (xfer) begin
                    DATA_VALID <= 1'b0;
                    DATA_OUT   <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_geiger_packetizer_multi.sv
// tb/tb_geiger_packetizer_multi.sv - directed self-checking bench for geiger_packetizer_multi
// Short windows and dead time; second instance with 8-bit counts exercises saturation.
module tb_geiger_packetizer_multi;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, en1;
    logic [1:0]  geig, geig1;
    logic [47:0] ts;
    logic        ready;
    logic        ready1;
    logic [7:0]  dout, dout1;
    logic        dv, dv1, fs, fs1, ovf, ovf1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    geiger_packetizer_multi #(
        .NUM_CH(2), .CNT_W(16), .TS_W(48), .WINDOW_CYC(100), .DEADTIME_CYC(5), .SYNC_BYTE(8'hA5)
    ) u_dut (
        .CLK_1MHZ(clk), .NSYSRESET(rst_n), .EN(en), .GEIG_IN(geig), .TIMESTAMP(ts),
        .DATA_OUT(dout), .DATA_VALID(dv), .DATA_READY(ready), .FRAME_START(fs), .OVERRUN(ovf)
    );

    geiger_packetizer_multi #(
        .NUM_CH(2), .CNT_W(8), .TS_W(48), .WINDOW_CYC(2000), .DEADTIME_CYC(5), .SYNC_BYTE(8'hA5)
    ) u_sat (
        .CLK_1MHZ(clk), .NSYSRESET(rst_n), .EN(en1), .GEIG_IN(geig1), .TIMESTAMP(ts),
        .DATA_OUT(dout1), .DATA_VALID(dv1), .DATA_READY(ready1), .FRAME_START(fs1), .OVERRUN(ovf1)
    );

    task automatic check(input logic [63:0] obs, input logic [63:0] expv, input string tag);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic pulse(input logic [1:0] m, input int gap);
        geig = m;
        @(negedge clk);
        geig = 2'b00;
        repeat (gap - 1) @(negedge clk);
    endtask

    // Waits for a packet and checks every byte against counts c0/c1.
    task automatic get_packet(input logic [15:0] c0, input logic [15:0] c1, input int stall_at,
                              input int stall_len, input int inj_at, input int rst_at, input int exp_ovr);
        logic [7:0] expb [12];
        int t;
        int ovr;
        expb[0] = 8'hA5;
        expb[1] = 8'h00; expb[2] = 8'h00; expb[3] = 8'h00; expb[4] = 8'h00;
        expb[5] = 8'h27; expb[6] = 8'h10;
        expb[7] = c0[15:8]; expb[8] = c0[7:0];
        expb[9] = c1[15:8]; expb[10] = c1[7:0];
        expb[11] = 8'h00;
        for (int i = 1; i <= 10; i++) expb[11] = expb[11] ^ expb[i];
        t = 0;
        ovr = 0;
        while (dv !== 1'b1 && t < 400) begin
            @(negedge clk);
            ovr += int'(ovf);
            t++;
        end
        check(64'(dv), 64'd1, "pkt_start");
        for (int i = 0; i < 12; i++) begin
            if (i == rst_at) begin
                rst_n = 1'b0;
                #1;
                check(64'(dout), 64'd0, "rst_data");
                check(64'(dv), 64'd0, "rst_valid");
                check(64'(fs), 64'd0, "rst_frame_start");
                check(64'(ovf), 64'd0, "rst_overrun");
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            check(64'(dout), 64'(expb[i]), $sformatf("byte%0d", i));
            check(64'(fs), 64'(i == 0), $sformatf("frame_start%0d", i));
            if (i == stall_at) begin
                ready = 1'b0;
                for (int j = 0; j < stall_len; j++) begin
                    @(negedge clk);
                    ovr += int'(ovf);
                    geig[1] = (j == inj_at);
                    check(64'(dv), 64'd1, "stall_valid");
                    check(64'(dout), 64'(expb[i]), "stall_data");
                end
                geig[1] = 1'b0;
                ready = 1'b1;
            end
            @(negedge clk);
            ovr += int'(ovf);
        end
        check(64'(dv), 64'd0, "valid_drop");
        check(64'(ovr), 64'(exp_ovr), "overrun_count");
    endtask

    initial begin
        logic [7:0] sat_exp [10];
        int t;
        rst_n  = 1'b0;
        en     = 1'b0;
        en1    = 1'b0;
        geig   = 2'b00;
        geig1  = 2'b00;
        ts     = 48'h000000002710;
        ready  = 1'b1;
        ready1 = 1'b1;
        repeat (3) @(negedge clk);
        check(64'(dout), 64'd0, "reset_data");
        check(64'(dv), 64'd0, "reset_valid");
        check(64'(fs), 64'd0, "reset_frame_start");
        check(64'(ovf), 64'd0, "reset_overrun");
        rst_n = 1'b1;
        @(negedge clk);
        en = 1'b1;

        // Three isolated ch0 pulses.
        pulse(2'b01, 20); pulse(2'b01, 20); pulse(2'b01, 20);
        get_packet(16'd3, 16'd0, -1, 0, -1, -1, 0);

        // Second ch0 edge falls inside dead time; ch1 is independent.
        pulse(2'b01, 3); pulse(2'b11, 10); pulse(2'b01, 10);
        get_packet(16'd2, 16'd1, -1, 0, -1, -1, 0);

        // Consumer stall at byte 4.
        pulse(2'b01, 10);
        get_packet(16'd1, 16'd0, 4, 20, -1, -1, 0);

        // Stall across the next window close: that window (with a ch1 pulse) is dropped.
        pulse(2'b01, 8); pulse(2'b01, 8);
        get_packet(16'd2, 16'd0, 1, 120, 20, -1, 1);
        pulse(2'b01, 8);
        get_packet(16'd1, 16'd0, -1, 0, -1, -1, 0);

        // Reset mid-packet, then a clean packet after one full window.
        pulse(2'b10, 8);
        get_packet(16'd0, 16'd1, -1, 0, -1, 6, 0);
        for (int k = 0; k < 5; k++) pulse(2'b01, 8);
        pulse(2'b10, 8); pulse(2'b10, 8);
        get_packet(16'd5, 16'd2, -1, 0, -1, -1, 0);

        // Saturation with 8-bit counts.
        en1 = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 300; k++) begin
            geig1[0] = 1'b1;
            @(negedge clk);
            geig1[0] = 1'b0;
            repeat (5) @(negedge clk);
        end
        sat_exp[0] = 8'hA5; sat_exp[1] = 8'h00; sat_exp[2] = 8'h00; sat_exp[3] = 8'h00;
        sat_exp[4] = 8'h00; sat_exp[5] = 8'h27; sat_exp[6] = 8'h10; sat_exp[7] = 8'hFF;
        sat_exp[8] = 8'h00; sat_exp[9] = 8'hC8;
        t = 0;
        while (dv1 !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check(64'(dv1), 64'd1, "sat_pkt_start");
        for (int i = 0; i < 10; i++) begin
            check(64'(dout1), 64'(sat_exp[i]), $sformatf("sat_byte%0d", i));
            @(negedge clk);
        end
        check(64'(dv1), 64'd0, "sat_valid_drop");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/geiger_packetizer_multi.md
Name: geiger_packetizer_multi

Overview:
- Multi-channel successor to the single-stack Geiger harness path. Counts pulses on NUM_CH Geiger tube inputs over a fixed gate window and applies per-channel dead-time rejection.
- At each window close, snapshots the counts with the 48-bit mission timestamp.
- Streams the snapshot as a framed, checksummed byte packet on an 8-bit bus with a valid/ready handshake toward the downlink formatter.

Parameters:
- NUM_CH, 2: number of Geiger channels (1..8).
- CNT_W, 16: per-channel count width; multiple of 8.
- TS_W, 48: timestamp width; multiple of 8.
- WINDOW_CYC, 1000000: gate window length in CLK_1MHZ cycles (1 s).
- DEADTIME_CYC, 100: per-channel re-trigger lockout in cycles (100 us).
- SYNC_BYTE, 8'hA5: frame header byte.

Ports:
- CLK_1MHZ, in, 1: system clock, 1 MHz.
- NSYSRESET, in, 1: asynchronous active-low reset.
- EN, in, 1: enables gating and counting.
- GEIG_IN, in, NUM_CH: raw asynchronous tube pulses, active high.
- TIMESTAMP, in, TS_W: free-running mission time, synchronous to CLK_1MHZ.
- DATA_OUT, out, 8: packet byte.
- DATA_VALID, out, 1: DATA_OUT holds a valid byte.
- DATA_READY, in, 1: consumer accepts the byte.
- FRAME_START, out, 1: high while the SYNC byte is presented.
- OVERRUN, out, 1: one-cycle pulse when a snapshot is dropped.

Behaviour:
- Reset: all outputs 0; live counters, shadow registers, window counter, dead-time counters and sync flops 0; FSM in IDLE.
- Input path per channel:
  - 2-FF synchroniser, then a rising-edge detect against a third flop.
  - A low-to-high input transition sampled at edge k produces a counted pulse at edge k+3.
- Dead time:
  - An accepted edge loads that channel's dead-time counter with DEADTIME_CYC-1.
  - Edges are ignored while the counter is non-zero.
  - Counters are independent per channel.
- Counting: each accepted edge increments the channel's live count, saturating at 2^CNT_W-1 with no wrap.
- Window counter:
  - Counts 0..WINDOW_CYC-1 while EN=1.
  - On the terminal cycle (value WINDOW_CYC-1): copy live counts plus the current TIMESTAMP into shadow registers, clear the live counts, wrap the window counter to 0.
  - An edge accepted on the terminal cycle is included in the closing snapshot (count+1 is latched); the next window starts at 0.
- EN=0:
  - Window counter and live counts are held at 0; edges are ignored but dead-time counters still run.
  - A packet already in flight completes normally.
  - On EN rising, the first window is a full WINDOW_CYC long.
- Packetizer FSM states: IDLE, SYNC, TS, CNT, CHK.
  - IDLE -> SYNC on the cycle after a snapshot.
  - SYNC sends SYNC_BYTE with FRAME_START=1.
  - TS sends TS_W/8 bytes, MSB first.
  - CNT sends channel 0 first, CNT_W/8 bytes per channel, MSB first.
  - CHK sends the XOR of every byte after SYNC, then returns to IDLE.
  - Packet length = 1 + TS_W/8 + NUM_CH*CNT_W/8 + 1; 12 bytes at defaults.
- Handshake:
  - A byte transfers on a rising edge where DATA_VALID & DATA_READY.
  - DATA_VALID, once raised, stays high and DATA_OUT stays stable until the transfer.
  - The next byte appears on the following cycle, so back-to-back READY gives 1 byte/cycle.
  - DATA_VALID falls in the cycle after the CHK transfer.
  - DATA_READY is ignored when DATA_VALID=0.
- Overrun:
  - A snapshot arriving while the FSM is not in IDLE is discarded: shadow registers are unchanged and OVERRUN pulses for one cycle.
  - The live counters are still cleared and the window restarts.
- Reset mid-packet: aborts immediately and asynchronously; no partial resume after release.

Test Plan:
- WINDOW_CYC=100, DEADTIME_CYC=5, TIMESTAMP held at 48'h000000002710, 3 isolated ch0 pulses and none on ch1, READY tied high -> 12 bytes: A5 00 00 00 00 27 10 00 03 00 00 34; FRAME_START only on byte 0.
- Two ch0 pulses 3 cycles apart (inside dead time) plus one pulse 10 cycles later -> ch0 count = 2.
- CNT_W=8, 300 pulses spaced 6 cycles in a WINDOW_CYC=2000 window -> ch0 count byte = FF.
- READY held low 20 cycles at byte 4 -> DATA_VALID stays high and DATA_OUT stays 00 throughout; the remaining bytes are correct after READY rises.
- READY held low past the next window close -> OVERRUN pulses exactly once; the first packet is intact; the following window's packet reports only its own counts.
- NSYSRESET asserted at byte 6 -> all outputs 0 asynchronously; after release and one full window, a complete, correctly checksummed packet is sent.
